mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist_pkg.sv | 17 +
 rtl/mem_bist.sv | 125 ++++++++++++
 tb/tb_mem_bist.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared definitions for the march-free write/read-back memory BIST.
package mem_bist_pkg;

   // Default geometry: 32 locations of 8 bits.
   localparam int unsigned MemBistAddrWidth = 5;
   localparam int unsigned MemBistDataWidth = 8;

   typedef enum logic [2:0] {
      StIdle,
      StWSetup,
      StWPulse,
      StRAssert,
      StRSample,
      StDone
   } state_e;

endpackage

// File: rtl/mem_bist.sv
// Memory BIST: writes an address-derived pattern to every location, then reads each
// location back and stops at the first mismatch, reporting its address and data.
module mem_bist
   import mem_bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = MemBistAddrWidth,
   parameter int unsigned DATA_WIDTH  = MemBistDataWidth,
   parameter bit          PATTERN_INV = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   output logic                  mem_write,
   inout  wire  [DATA_WIDTH-1:0] mem_data
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  pass_q, pass_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
   logic [DATA_WIDTH-1:0] pattern;
   logic                  last_addr;
   logic                  drive;

   // Expected word for the current address: zero-extended address, optionally inverted.
   always_comb begin
      pattern = DATA_WIDTH'(cnt_q);
      if (PATTERN_INV) begin
         pattern = ~pattern;
      end
   end

   assign last_addr = (cnt_q == {ADDR_WIDTH{1'b1}});

   // State and result registers; reset is synchronous and overrides start.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pass_q      <= pass_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
      end
   end

   // Sequencing: two cycles per write, two cycles per read, stop on first miscompare.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pass_d      = pass_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StWSetup;
               cnt_d       = '0;
               pass_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         StWSetup: begin
            state_d = StWPulse;
         end
         StWPulse: begin
            if (last_addr) begin
               state_d = StRAssert;
               cnt_d   = '0;
            end else begin
               state_d = StWSetup;
               cnt_d   = cnt_q + ADDR_WIDTH'(1);
            end
         end
         StRAssert: begin
            state_d = StRSample;
         end
         StRSample: begin
            // 4-state compare so a floating or unknown bus is a failure.
            if (mem_data !== pattern) begin
               state_d     = StDone;
               fail_addr_d = cnt_q;
               fail_data_d = mem_data;
            end else if (last_addr) begin
               state_d = StDone;
               pass_d  = 1'b1;
            end else begin
               state_d = StRAssert;
               cnt_d   = cnt_q + ADDR_WIDTH'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // All outputs decode registered state only; nothing depends on start or mem_data.
   assign busy      = (state_q == StWSetup) || (state_q == StWPulse) ||
                      (state_q == StRAssert) || (state_q == StRSample);
   assign done      = (state_q == StDone);
   assign pass      = pass_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign mem_addr  = cnt_q;
   assign mem_read  = (state_q == StRAssert) || (state_q == StRSample);
   assign mem_write = (state_q == StWPulse);
   assign drive     = (state_q == StWSetup) || (state_q == StWPulse);
   assign mem_data  = drive ? pattern : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist: two instances (plain and inverted pattern), each on its
// own behavioural 32x8 memory. Bus 0 idles high via pullups, bus 1 idles low via
// pulldowns, so a released bus reads as a known value.
module tb_mem_bist;

   logic clk;
   logic rst_;
   logic start0, start1;
   logic busy0, done0, pass0, mem_read0, mem_write0;
   logic busy1, done1, pass1, mem_read1, mem_write1;
   logic [4:0] fail_addr0, mem_addr0, fail_addr1, mem_addr1;
   logic [7:0] fail_data0, fail_data1;
   wire  [7:0] mem_data0, mem_data1;

   logic [7:0] mem0 [32];
   logic [7:0] mem1 [32];
   logic [7:0] rd0;
   logic       stuck;
   logic       mon_en;

   int checks = 0;
   int errors = 0;

   mem_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .PATTERN_INV(1'b0)) dut0 (
      .clk(clk), .rst_(rst_), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
      .fail_addr(fail_addr0), .fail_data(fail_data0), .mem_addr(mem_addr0),
      .mem_read(mem_read0), .mem_write(mem_write0), .mem_data(mem_data0)
   );

   mem_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .PATTERN_INV(1'b1)) dut1 (
      .clk(clk), .rst_(rst_), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
      .fail_addr(fail_addr1), .fail_data(fail_data1), .mem_addr(mem_addr1),
      .mem_read(mem_read1), .mem_write(mem_write1), .mem_data(mem_data1)
   );

   for (genvar i = 0; i < 8; i++) begin : g_pull
      pullup   pu (mem_data0[i]);
      pulldown pd (mem_data1[i]);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory 0 optionally has bit 0 of location 5 stuck at 0.
   always_comb begin
      rd0 = mem0[mem_addr0];
      if (stuck && (mem_addr0 == 5'd5)) begin
         rd0[0] = 1'b0;
      end
   end
   assign mem_data0 = mem_read0 ? rd0 : 8'bz;
   assign mem_data1 = mem_read1 ? mem1[mem_addr1] : 8'bz;

   // Memories capture on the write strobe.
   always @(posedge clk) begin
      if (mem_write0) mem0[mem_addr0] <= mem_data0;
      if (mem_write1) mem1[mem_addr1] <= mem_data1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every-cycle bus protocol checks once reset has been applied.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("rw_overlap0", {31'd0, mem_read0 & mem_write0}, 32'd0);
         chk("rw_overlap1", {31'd0, mem_read1 & mem_write1}, 32'd0);
         if (!busy0) chk("bus_released0", {24'd0, mem_data0}, 32'h0000_00FF);
         if (!busy1) chk("bus_released1", {24'd0, mem_data1}, 32'h0000_0000);
      end
   end

   // Called at the negedge of run cycle N+1. Leaves at the first negedge with done=1,
   // or at the negedge of cycle N+bound. lat = cycles seen before done.
   task automatic run(input bit sel, input int pa, input int pb, input int bound,
                      output int lat, output int bc, output bit saw6);
      bit d, b, r;
      logic [4:0] a;
      lat  = 0;
      bc   = 0;
      saw6 = 1'b0;
      d    = sel ? done1 : done0;
      while (!d && lat < bound) begin
         lat++;
         b = sel ? busy1 : busy0;
         r = sel ? mem_read1 : mem_read0;
         a = sel ? mem_addr1 : mem_addr0;
         if (b) bc++;
         if (r && a == 5'd6) saw6 = 1'b1;
         if (sel) start1 = (lat == pa || lat == pb);
         else     start0 = (lat == pa || lat == pb);
         if (lat < bound) begin
            @(negedge clk);
            d = sel ? done1 : done0;
         end
      end
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   initial begin
      int  lat, bc;
      bit  saw6;
      logic [7:0] e;

      rst_   = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      stuck  = 1'b0;
      mon_en = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values.
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_pass", {31'd0, pass0}, 32'd0);
      chk("rst_fail_addr", {27'd0, fail_addr0}, 32'd0);
      chk("rst_fail_data", {24'd0, fail_data0}, 32'd0);
      chk("rst_mem_addr", {27'd0, mem_addr0}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read0}, 32'd0);
      chk("rst_mem_write", {31'd0, mem_write0}, 32'd0);
      chk("rst_bus", {24'd0, mem_data0}, 32'h0000_00FF);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      mon_en = 1'b1;
      rst_   = 1'b1;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy0}, 32'd0);

      // Clean run.
      start0 = 1'b1;
      @(negedge clk);
      chk("first_addr", {27'd0, mem_addr0}, 32'd0);
      chk("first_wr_setup", {31'd0, mem_write0}, 32'd0);
      run(1'b0, -1, -1, 300, lat, bc, saw6);
      chk("clean_latency", lat, 32'd128);
      chk("clean_busy_cycles", bc, 32'd128);
      chk("clean_done", {31'd0, done0}, 32'd1);
      chk("clean_pass", {31'd0, pass0}, 32'd1);
      chk("clean_busy_off", {31'd0, busy0}, 32'd0);
      for (int i = 0; i < 32; i++) chk("clean_mem", {24'd0, mem0[i]}, i);
      repeat (5) @(negedge clk);
      chk("done_held", {31'd0, done0}, 32'd1);
      chk("pass_held", {31'd0, pass0}, 32'd1);

      // Stuck-at-0 on bit 0 of location 5; restart straight from DONE.
      stuck  = 1'b1;
      start0 = 1'b1;
      @(negedge clk);
      chk("restart_clears_done", {31'd0, done0}, 32'd0);
      run(1'b0, -1, -1, 300, lat, bc, saw6);
      chk("stuck_latency", lat, 32'd76);
      chk("stuck_done", {31'd0, done0}, 32'd1);
      chk("stuck_pass", {31'd0, pass0}, 32'd0);
      chk("stuck_fail_addr", {27'd0, fail_addr0}, 32'd5);
      chk("stuck_fail_data", {24'd0, fail_data0}, 32'h04);
      chk("stuck_no_read6", {31'd0, saw6}, 32'd0);
      chk("stuck_read_off", {31'd0, mem_read0}, 32'd0);
      repeat (3) @(negedge clk);
      chk("stuck_still_read_off", {31'd0, mem_read0}, 32'd0);
      stuck = 1'b0;

      // Reset at run cycle 40, with start held high during reset.
      start0 = 1'b1;
      @(negedge clk);
      run(1'b0, -1, -1, 40, lat, bc, saw6);
      chk("midrun_reached", lat, 32'd40);
      rst_   = 1'b0;
      start0 = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy0}, 32'd0);
      chk("midrst_done", {31'd0, done0}, 32'd0);
      chk("midrst_pass", {31'd0, pass0}, 32'd0);
      chk("midrst_fail_addr", {27'd0, fail_addr0}, 32'd0);
      chk("midrst_fail_data", {24'd0, fail_data0}, 32'd0);
      chk("midrst_mem_addr", {27'd0, mem_addr0}, 32'd0);
      chk("midrst_mem_read", {31'd0, mem_read0}, 32'd0);
      chk("midrst_mem_write", {31'd0, mem_write0}, 32'd0);
      chk("midrst_bus", {24'd0, mem_data0}, 32'h0000_00FF);
      rst_   = 1'b1;
      start0 = 1'b0;
      @(negedge clk);
      chk("start_in_reset_ignored", {31'd0, busy0}, 32'd0);
      start0 = 1'b1;
      @(negedge clk);
      run(1'b0, -1, -1, 300, lat, bc, saw6);
      chk("after_rst_latency", lat, 32'd128);
      chk("after_rst_pass", {31'd0, pass0}, 32'd1);

      // Start pulses at run cycles 10 and 70 must not disturb the run.
      start0 = 1'b1;
      @(negedge clk);
      run(1'b0, 10, 70, 300, lat, bc, saw6);
      chk("ignored_latency", lat, 32'd128);
      chk("ignored_busy_cycles", bc, 32'd128);
      chk("ignored_pass", {31'd0, pass0}, 32'd1);

      // Inverted pattern instance.
      start1 = 1'b1;
      @(negedge clk);
      run(1'b1, -1, -1, 300, lat, bc, saw6);
      chk("inv_latency", lat, 32'd128);
      chk("inv_done", {31'd0, done1}, 32'd1);
      chk("inv_pass", {31'd0, pass1}, 32'd1);
      chk("inv_mem0", {24'd0, mem1[0]}, 32'h0000_00FF);
      chk("inv_mem31", {24'd0, mem1[31]}, 32'h0000_00E0);
      for (int i = 0; i < 32; i++) begin
         e = ~8'(i);
         chk("inv_mem", {24'd0, mem1[i]}, {24'd0, e});
      end

      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
